// File: rtl/lcd_fmt_pkg.sv
// rtl/lcd_fmt_pkg.sv - shared states, character constants and hex helper for lcd_text_formatter
package lcd_fmt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        HEX,
        BCD,
        DEC,
        SWAP
    } fmt_state_e;

    // Label bytes, leftmost character in the top byte.
    localparam logic [23:0] LBL_R0    = 24'h52_30_3D;  // "R0="
    localparam logic [23:0] LBL_R1    = 24'h52_31_3D;  // "R1="
    localparam logic [7:0]  CHAR_ZERO = 8'h30;
    localparam logic [7:0]  CHAR_A_UP = 8'h41;
    localparam logic [7:0]  CHAR_A_LO = 8'h61;

    function automatic logic [7:0] hex2ascii(input logic [3:0] nibble, input logic upper);
        logic [7:0] base;
        if (nibble < 4'd10) begin
            return CHAR_ZERO + {4'b0000, nibble};
        end
        base = upper ? CHAR_A_UP : CHAR_A_LO;
        return base + {4'b0000, nibble} - 8'd10;
    endfunction

endpackage

// File: rtl/lcd_bin2bcd.sv
// rtl/lcd_bin2bcd.sv - 16-cycle iterative double-dabble binary to 5-digit BCD converter
//  Compiled only when LCD_FMT_DEC_EN is defined.
//  clk, rstn : clock, asynchronous active-low reset
//  start     : load bin and begin conversion (one cycle)
//  bin[15:0] : binary value sampled with start
//  done      : high in the cycle whose edge performs the final step; bcd valid from next cycle
//  bcd[19:0] : five BCD digits, digit 4 in bcd[19:16]
`ifdef LCD_FMT_DEC_EN
module lcd_bin2bcd (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        done,
    output logic [19:0] bcd
);

    logic        running;
    logic [3:0]  step;
    logic [15:0] bin_r;
    logic [19:0] bcd_r;
    logic [19:0] adj;

    // Add-3 correction on every digit that would overflow past 9 after the shift.
    always_comb begin
        adj = bcd_r;
        for (int d = 0; d < 5; d++) begin
            if (bcd_r[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = bcd_r[4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            running <= 1'b0;
            step    <= 4'd0;
            bin_r   <= 16'd0;
            bcd_r   <= 20'd0;
        end else if (start) begin
            running <= 1'b1;
            step    <= 4'd0;
            bin_r   <= bin;
            bcd_r   <= 20'd0;
        end else if (running) begin
            bcd_r <= {adj[18:0], bin_r[15]};
            bin_r <= {bin_r[14:0], 1'b0};
            step  <= step + 4'd1;
            if (step == 4'd15) begin
                running <= 1'b0;
            end
        end
    end

    assign done = running && (step == 4'd15);
    assign bcd  = bcd_r;

endmodule
`endif

// File: rtl/lcd_text_formatter.sv
// rtl/lcd_text_formatter.sv - renders two 16-bit values as a double-buffered 2-line LCD text frame
//  Optional feature macro: LCD_FMT_DEC_EN (line 2 shows val1 as 5-digit decimal).
//  clk          : system clock
//  rstn         : asynchronous active-low reset
//  refresh      : frame request, sampled every cycle; merges into one pending request while busy
//  val0, val1   : values for line 1 and line 2, snapshotted at the start of a frame
//  rd_addr      : front-buffer character index (0..COLS-1 line 1, COLS..2*COLS-1 line 2)
//  rd_char      : registered character at rd_addr, 1-cycle latency
//  frame_valid  : sticky, set once the first frame is visible
//  frame_done   : 1-cycle pulse when a new frame becomes visible
//  busy         : high while a frame is being built
module lcd_text_formatter
    import lcd_fmt_pkg::*;
#(
    parameter int         COLS       = 16,
    parameter logic [7:0] BLANK_CHAR = 8'h20,
    parameter bit         HEX_UPPER  = 1'b1,
    localparam int        FRAME      = 2 * COLS,
    localparam int        ADDR_W     = $clog2(2 * COLS)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              refresh,
    input  logic [15:0]       val0,
    input  logic [15:0]       val1,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_char,
    output logic              frame_valid,
    output logic              frame_done,
    output logic              busy
);

`ifdef LCD_FMT_DEC_EN
    localparam logic [2:0] HEX_LAST = 3'd3;
`else
    localparam logic [2:0] HEX_LAST = 3'd7;
`endif

    fmt_state_e        state, state_nxt;
    logic              pending;
    logic [2:0]        cnt;
    logic [15:0]       snap0, snap1;
    logic [7:0]        back  [FRAME];
    logic [7:0]        front [FRAME];

    logic [15:0]       hex_word;
    logic [3:0]        hex_nib;
    logic [ADDR_W-1:0] hex_pos;

    // Fixed part of the layout: labels at the start of each line, blanks elsewhere.
    function automatic logic [7:0] layout_char(input int pos);
        logic [7:0] ch;
        ch = BLANK_CHAR;
        if (pos == 0)        ch = LBL_R0[23:16];
        if (pos == 1)        ch = LBL_R0[15:8];
        if (pos == 2)        ch = LBL_R0[7:0];
        if (pos == COLS)     ch = LBL_R1[23:16];
        if (pos == COLS + 1) ch = LBL_R1[15:8];
        if (pos == COLS + 2) ch = LBL_R1[7:0];
        return ch;
    endfunction

    // Counts 0..3 address val0 digits MSB-first, 4..7 address val1 digits.
    always_comb begin
        hex_word = cnt[2] ? snap1 : snap0;
        hex_nib  = hex_word[{~cnt[1:0], 2'b00} +: 4];
        hex_pos  = cnt[2] ? ADDR_W'(COLS + 3) + ADDR_W'(cnt[1:0])
                          : ADDR_W'(3) + ADDR_W'(cnt[1:0]);
    end

`ifdef LCD_FMT_DEC_EN
    logic              bcd_start;
    logic              bcd_done;
    logic [19:0]       bcd_q;
    logic [2:0]        dec_sel;
    logic [3:0]        dec_digit;
    logic [ADDR_W-1:0] dec_pos;

    assign bcd_start = (state == HEX) && (state_nxt == BCD);

    lcd_bin2bcd u_bin2bcd (
        .clk   (clk),
        .rstn  (rstn),
        .start (bcd_start),
        .bin   (snap1),
        .done  (bcd_done),
        .bcd   (bcd_q)
    );

    // Most significant decimal digit first.
    always_comb begin
        dec_sel   = 3'd4 - cnt;
        dec_digit = bcd_q[{dec_sel, 2'b00} +: 4];
        dec_pos   = ADDR_W'(COLS + 3) + ADDR_W'(cnt);
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (refresh || pending) state_nxt = CAPTURE;
            CAPTURE: state_nxt = HEX;
`ifdef LCD_FMT_DEC_EN
            HEX:     if (cnt == HEX_LAST) state_nxt = BCD;
            BCD:     if (bcd_done) state_nxt = DEC;
            DEC:     if (cnt == 3'd4) state_nxt = SWAP;
`else
            HEX:     if (cnt == HEX_LAST) state_nxt = SWAP;
`endif
            SWAP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            pending     <= 1'b0;
            cnt         <= 3'd0;
            snap0       <= 16'd0;
            snap1       <= 16'd0;
            frame_valid <= 1'b0;
            frame_done  <= 1'b0;
            rd_char     <= BLANK_CHAR;
            for (int i = 0; i < FRAME; i++) begin
                back[i]  <= BLANK_CHAR;
                front[i] <= BLANK_CHAR;
            end
        end else begin
            state      <= state_nxt;
            frame_done <= (state == SWAP);
            if (state == SWAP) begin
                frame_valid <= 1'b1;
            end

            // A request while idle starts the frame directly; otherwise it is remembered once.
            if (state == IDLE) begin
                pending <= 1'b0;
            end else if (refresh) begin
                pending <= 1'b1;
            end

            cnt <= (state_nxt != state) ? 3'd0 : cnt + 3'd1;

            case (state)
                CAPTURE: begin
                    snap0 <= val0;
                    snap1 <= val1;
                    for (int i = 0; i < FRAME; i++) begin
                        back[i] <= layout_char(i);
                    end
                end
                HEX: back[hex_pos] <= hex2ascii(hex_nib, HEX_UPPER);
`ifdef LCD_FMT_DEC_EN
                DEC: back[dec_pos] <= CHAR_ZERO + {4'b0000, dec_digit};
`endif
                SWAP: begin
                    for (int i = 0; i < FRAME; i++) begin
                        front[i] <= back[i];
                    end
                end
                default: ;
            endcase

            // On the swap edge the read bypasses to the back buffer so it sees the new frame.
            if ({1'b0, rd_addr} >= (ADDR_W + 1)'(FRAME)) begin
                rd_char <= BLANK_CHAR;
            end else if (state == SWAP) begin
                rd_char <= back[rd_addr];
            end else begin
                rd_char <= front[rd_addr];
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_lcd_text_formatter.sv
// tb/tb_lcd_text_formatter.sv - self-checking bench for lcd_text_formatter
module tb_lcd_text_formatter;

`ifdef LCD_FMT_DEC_EN
    localparam int LAT = 28;
`else
    localparam int LAT = 11;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        refresh = 1'b0;
    logic [15:0] val0 = 16'h0000;
    logic [15:0] val1 = 16'h0000;
    logic [4:0]  rd_addr = 5'd0;
    logic [7:0]  rd_char;
    logic        frame_valid;
    logic        frame_done;
    logic        busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lcd_text_formatter dut (
        .clk         (clk),
        .rstn        (rstn),
        .refresh     (refresh),
        .val0        (val0),
        .val1        (val1),
        .rd_addr     (rd_addr),
        .rd_char     (rd_char),
        .frame_valid (frame_valid),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    typedef struct {
        logic [15:0] v0;
        logic [15:0] v1;
        string       l1;
        string       l2;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference: text of the frame from the layout rules, computed arithmetically.
    function automatic logic [7:0] model_char(input int pos, input logic [15:0] v0, input logic [15:0] v1);
        int line;
        int col;
        int v;
        int d;
        int p;
        line = pos / 16;
        col  = pos % 16;
        v    = (line == 1) ? int'(v1) : int'(v0);
        if (col == 0) return 8'h52;
        if (col == 1) return (line == 1) ? 8'h31 : 8'h30;
        if (col == 2) return 8'h3D;
`ifdef LCD_FMT_DEC_EN
        if (line == 1) begin
            if (col >= 3 && col < 8) begin
                p = 1;
                for (int k = 0; k < 7 - col; k++) p = p * 10;
                d = (v / p) % 10;
                return 8'(32'h30 + d);
            end
            return 8'h20;
        end
`endif
        if (col >= 3 && col < 7) begin
            d = (v >> (4 * (6 - col))) & 15;
            return (d < 10) ? 8'(32'h30 + d) : 8'(32'h41 + d - 10);
        end
        return 8'h20;
    endfunction

    task automatic read_at(input int addr, output logic [7:0] ch);
        rd_addr = 5'(addr);
        @(negedge clk);
        ch = rd_char;
    endtask

    task automatic check_line_str(input string tag, input int line, input string s);
        logic [7:0] ch;
        int exp;
        for (int col = 0; col < 16; col++) begin
            read_at(line * 16 + col, ch);
            exp = (col < s.len()) ? int'(s[col]) : 32'h20;
            check($sformatf("%s_pos%0d", tag, line * 16 + col), int'(ch), exp);
        end
    endtask

    task automatic check_frame_model(input string tag, input logic [15:0] v0, input logic [15:0] v1);
        logic [7:0] ch;
        for (int pos = 0; pos < 32; pos++) begin
            read_at(pos, ch);
            check($sformatf("%s_pos%0d", tag, pos), int'(ch), int'(model_char(pos, v0, v1)));
        end
    endtask

    // Pulses refresh for one cycle and returns the cycle count until frame_done (0 on timeout).
    task automatic run_frame(input logic [15:0] v0, input logic [15:0] v1, output int lat, output int busy_bad);
        val0 = v0;
        val1 = v1;
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        lat = 1;
        busy_bad = 0;
        while (!frame_done && lat < 100) begin
            if (!busy) busy_bad++;
            @(negedge clk);
            lat++;
        end
        if (!frame_done) lat = 0;
    endtask

    initial begin
        int lat;
        int bad;
        int done_cnt;
        int first_done;
        int second_done;
        int busy_low;
        int busy_at_lat;
        int busy_after;
        int last_done;
        int gap_bad;
        logic [7:0] ch;
        logic [15:0] rv0;
        logic [15:0] rv1;

        vecs[0] = '{16'h1A2F, 16'h00C3, "R0=1A2F",
`ifdef LCD_FMT_DEC_EN
                    "R1=00195"};
`else
                    "R1=00C3"};
`endif
        vecs[1] = '{16'h0000, 16'hFFFF, "R0=0000",
`ifdef LCD_FMT_DEC_EN
                    "R1=65535"};
`else
                    "R1=FFFF"};
`endif
        vecs[2] = '{16'hABCD, 16'h0000, "R0=ABCD",
`ifdef LCD_FMT_DEC_EN
                    "R1=00000"};
`else
                    "R1=0000"};
`endif
        vecs[3] = '{16'h9087, 16'hBEEF, "R0=9087",
`ifdef LCD_FMT_DEC_EN
                    "R1=48879"};
`else
                    "R1=BEEF"};
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_valid", int'(frame_valid), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_rd_char", int'(rd_char), 32'h20);
        rstn = 1'b1;
        @(negedge clk);
        for (int pos = 0; pos < 32; pos += 5) begin
            read_at(pos, ch);
            check($sformatf("rst_blank_pos%0d", pos), int'(ch), 32'h20);
        end

        // Directed table
        for (int v = 0; v < 4; v++) begin
            run_frame(vecs[v].v0, vecs[v].v1, lat, bad);
            check($sformatf("vec%0d_latency", v), lat, LAT);
            check($sformatf("vec%0d_busy_during_build", v), bad, 0);
            check($sformatf("vec%0d_busy_after", v), int'(busy), 0);
            check($sformatf("vec%0d_frame_valid", v), int'(frame_valid), 1);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse_width", v), int'(frame_done), 0);
            check_line_str($sformatf("vec%0d_l1", v), 0, vecs[v].l1);
            check_line_str($sformatf("vec%0d_l2", v), 1, vecs[v].l2);
        end

        // Snapshot: input change after the capture edge does not reach the frame
        val0 = 16'h1A2F;
        val1 = 16'h00C3;
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        @(negedge clk);
        val0 = 16'hFFFF;
        lat = 2;
        while (!frame_done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("snap_latency", lat, LAT);
        check_line_str("snap_l1", 0, "R0=1A2F");

        // Request during a build: pending restarts immediately, second request merges
        val0 = 16'h2222;
        val1 = 16'h3333;
        refresh = 1'b1;
        done_cnt = 0;
        first_done = 0;
        second_done = 0;
        busy_low = 0;
        busy_at_lat = -1;
        busy_after = -1;
        for (int c = 1; c <= 2 * LAT + 15; c++) begin
            @(negedge clk);
            if (frame_done) begin
                done_cnt++;
                if (done_cnt == 1) first_done = c;
                if (done_cnt == 2) second_done = c;
            end
            if (c < 2 * LAT && !busy) busy_low++;
            if (c == LAT) busy_at_lat = int'(busy);
            if (c == LAT + 1) busy_after = int'(busy);
            refresh = (c == 4 || c == 7) ? 1'b1 : 1'b0;
        end
        check("pend_done_count", done_cnt, 2);
        check("pend_first_done", first_done, LAT);
        check("pend_second_done", second_done, 2 * LAT);
        check("pend_busy_gap", busy_at_lat, 0);
        check("pend_busy_restart", busy_after, 1);
        check("pend_busy_low_cycles", busy_low, 1);

        // Read port: out-of-range and latency
        run_frame(16'h1A2F, 16'h00C3, lat, bad);
        check("rd_setup_latency", lat, LAT);
        read_at(31, ch);
        check("rd_addr31", int'(ch), 32'h20);
        read_at(40, ch);
        check("rd_addr40_wrapped", int'(ch), 32'h20);
        read_at(3, ch);
        check("rd_addr3", int'(ch), 32'h31);
        rd_addr = 5'd0;
        #1;
        check("rd_latency_hold", int'(rd_char), 32'h31);
        @(negedge clk);
        check("rd_latency_update", int'(rd_char), 32'h52);

        // Front stays stable during a build; read at the swap edge sees the new frame
        rd_addr = 5'd3;
        @(negedge clk);
        val0 = 16'h7000;
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        bad = 0;
        lat = 1;
        while (!frame_done && lat < 100) begin
            if (rd_char != 8'h31) bad++;
            @(negedge clk);
            lat++;
        end
        check("stable_latency", lat, LAT);
        check("stable_while_busy", bad, 0);
        check("swap_edge_read", int'(rd_char), 32'h37);

        // Randomized frames against the reference model
        for (int r = 0; r < 12; r++) begin
            rv0 = 16'($urandom);
            rv1 = 16'($urandom);
            if (r == 0) rv1 = 16'd0;
            if (r == 1) rv1 = 16'd65535;
            run_frame(rv0, rv1, lat, bad);
            check($sformatf("rnd%0d_latency", r), lat, LAT);
            check_frame_model($sformatf("rnd%0d", r), rv0, rv1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // refresh held high: back-to-back frames at the nominal period
        refresh = 1'b1;
        done_cnt = 0;
        last_done = 0;
        gap_bad = 0;
        for (int c = 1; c <= 4 * LAT + 2; c++) begin
            @(negedge clk);
            if (frame_done) begin
                if (done_cnt > 0 && c - last_done != LAT) gap_bad++;
                done_cnt++;
                last_done = c;
            end
        end
        refresh = 1'b0;
        check("held_frame_count", done_cnt, 4);
        check("held_period", gap_bad, 0);
        lat = 0;
        while (busy && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("held_drain", int'(busy), 0);
        @(negedge clk);

        // Reset in the middle of a build: nothing partial becomes visible
        val0 = 16'h5A5A;
        val1 = 16'hA5A5;
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_frame_valid", int'(frame_valid), 0);
        check("midrst_rd_char", int'(rd_char), 32'h20);
        @(negedge clk);
        rstn = 1'b1;
        bad = 0;
        for (int pos = 0; pos < 32; pos++) begin
            read_at(pos, ch);
            if (ch != 8'h20) bad++;
        end
        check("midrst_all_blank", bad, 0);
        bad = 0;
        for (int c = 0; c < LAT + 10; c++) begin
            @(negedge clk);
            if (frame_done || busy || frame_valid) bad++;
        end
        check("midrst_no_frame", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
